// File: rtl/camellia_fl_pipe_if.sv
// Valid/ready bundle around the Camellia FL pipeline.
// Input channel:  i_flin, i_ke1, i_valid (to block), o_ready (from block).
// Output channel: o_flout, o_valid (from block), i_ready (to block).
// Signal names use the block's point of view. The slave modport is the FL
// block. The master modport is whoever feeds it and drains it.
interface camellia_fl_pipe_if;
  logic [63:0] i_flin;
  logic [63:0] i_ke1;
  logic        i_valid;
  logic        o_ready;
  logic [63:0] o_flout;
  logic        o_valid;
  logic        i_ready;

  modport slave (
    input  i_flin, i_ke1, i_valid, i_ready,
    output o_ready, o_flout, o_valid
  );

  modport master (
    output i_flin, i_ke1, i_valid, i_ready,
    input  o_ready, o_flout, o_valid
  );
endinterface

// File: rtl/camellia_fl_pipe.sv
// Two-stage pipelined Camellia FL function (forward direction).
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : camellia_fl_pipe_if.slave
//            in  : i_flin[63:0], i_ke1[63:0], i_valid, i_ready
//            out : o_ready, o_flout[63:0], o_valid
// Stage 1 computes y_R = x_R ^ rotl1(x_L & k_L).
// Stage 2 computes y_L = x_L ^ (y_R | k_R).
// Capacity is two entries. Full-rate flow holds under backpressure.
module camellia_fl_pipe (
  input logic               i_clk,
  input logic               i_rst,
  camellia_fl_pipe_if.slave bus
);

  localparam int unsigned HW = 32;

  logic [HW-1:0] r_s1_xl;
  logic [HW-1:0] r_s1_yr;
  logic [HW-1:0] r_s1_kr;
  logic          r_s1_valid;
  logic [63:0]   r_flout;
  logic          r_valid;

  logic [HW-1:0] w_and;
  logic [HW-1:0] w_yr;
  logic [HW-1:0] w_yl;
  logic          w_out_fire;
  logic          w_s2_load;
  logic          w_s1_accept;
  logic          w_in_fire;

  // Stage 1 datapath: AND, 1-bit left rotate, XOR.
  assign w_and = bus.i_flin[63:32] & bus.i_ke1[63:32];
  assign w_yr  = bus.i_flin[31:0] ^ {w_and[HW-2:0], w_and[HW-1]};

  // Stage 2 datapath: OR, XOR.
  assign w_yl  = r_s1_xl ^ (r_s1_yr | r_s1_kr);

  // Handshake. o_ready does not depend on i_valid. It is held low during reset.
  assign w_out_fire  = r_valid && bus.i_ready;
  assign w_s2_load   = r_s1_valid && (!r_valid || bus.i_ready);
  assign w_s1_accept = !i_rst && (!r_s1_valid || w_s2_load);
  assign w_in_fire   = bus.i_valid && w_s1_accept;

  assign bus.o_ready = w_s1_accept;
  assign bus.o_flout = r_flout;
  assign bus.o_valid = r_valid;

  // Pipeline registers. Data registers move only on their own load enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_xl    <= '0;
      r_s1_yr    <= '0;
      r_s1_kr    <= '0;
      r_s1_valid <= 1'b0;
      r_flout    <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_xl <= bus.i_flin[63:32];
        r_s1_yr <= w_yr;
        r_s1_kr <= bus.i_ke1[31:0];
      end

      if (w_in_fire)      r_s1_valid <= 1'b1;
      else if (w_s2_load) r_s1_valid <= 1'b0;

      if (w_s2_load) r_flout <= {w_yl, r_s1_yr};

      if (w_s2_load)       r_valid <= 1'b1;
      else if (w_out_fire) r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_camellia_fl_pipe.sv
// Directed bench for camellia_fl_pipe. It covers known vectors, latency,
// capacity and stall hold, a random-ready stream, an FL^-1 round trip, and
// reset with both stages full.
module tb_camellia_fl_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [63:0] got_q[$];

  camellia_fl_pipe_if bus ();

  camellia_fl_pipe dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every delivered output in order.
  always @(posedge clk) begin
    if (!rst && bus.o_valid && bus.i_ready) got_q.push_back(bus.o_flout);
  end

  function automatic logic [63:0] fl_ref(input logic [63:0] x, input logic [63:0] k);
    logic [31:0] t, yr, yl;
    t  = x[63:32] & k[63:32];
    yr = x[31:0] ^ {t[30:0], t[31]};
    yl = x[63:32] ^ (yr | k[31:0]);
    return {yl, yr};
  endfunction

  function automatic logic [63:0] fl_inv(input logic [63:0] y, input logic [63:0] k);
    logic [31:0] t, xl, xr;
    xl = y[63:32] ^ (y[31:0] | k[31:0]);
    t  = xl & k[63:32];
    xr = y[31:0] ^ {t[30:0], t[31]};
    return {xl, xr};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Send one vector into an empty pipe with i_ready=1, then check the timing.
  task automatic run_one(input string tag, input logic [63:0] x, input logic [63:0] k,
                         input logic [63:0] exp);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_flin  = x;
    bus.i_ke1   = k;
    #1 chk({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(bus.o_valid), 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(bus.o_valid), 64'd1);
    chk({tag, "_data"}, bus.o_flout, exp);
    @(negedge clk);
    chk({tag, "_once"}, 64'(bus.o_valid), 64'd0);
  endtask

  // Stream n random vectors. Optionally use random i_ready and the inverse check.
  task automatic run_stream(input string tag, input int n, input bit rnd, input bit rt);
    logic [63:0] xs[$];
    logic [63:0] ks[$];
    int sent;
    int budget;
    bit acc;
    got_q.delete();
    for (int i = 0; i < n; i++) begin
      xs.push_back({$urandom, $urandom});
      ks.push_back({$urandom, $urandom});
    end
    sent   = 0;
    budget = 0;
    while ((sent < n || got_q.size() < n) && budget < 20 * n + 50) begin
      @(negedge clk);
      bus.i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < n) begin
        bus.i_valid = 1'b1;
        bus.i_flin  = xs[sent];
        bus.i_ke1   = ks[sent];
      end else begin
        bus.i_valid = 1'b0;
      end
      #1 acc = bus.i_valid && bus.o_ready;
      @(posedge clk);
      if (acc) sent++;
      budget++;
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_count"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      if (rt) chk({tag, "_rt"}, fl_inv(got_q[i], ks[i]), xs[i]);
      else    chk({tag, "_data"}, got_q[i], fl_ref(xs[i], ks[i]));
    end
  endtask

  // With i_ready=0, feed up to 5 vectors. Exactly two are accepted.
  task automatic fill_stalled(output logic [63:0] first_exp, output logic [63:0] second_exp);
    logic [63:0] x0, k0, x1, k1;
    int acc_n;
    bit acc;
    x0 = 64'h0123_4567_89AB_CDEF; k0 = 64'hF0F0_F0F0_0F0F_0F0F;
    x1 = 64'hDEAD_BEEF_CAFE_F00D; k1 = 64'h1357_9BDF_2468_ACE0;
    first_exp  = fl_ref(x0, k0);
    second_exp = fl_ref(x1, k1);
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b1;
      bus.i_flin  = (acc_n == 0) ? x0 : (acc_n == 1) ? x1 : 64'h5555_AAAA_5555_AAAA;
      bus.i_ke1   = (acc_n == 0) ? k0 : (acc_n == 1) ? k1 : 64'hFFFF_FFFF_FFFF_FFFF;
      #1 acc = bus.o_ready;
      @(posedge clk);
      if (acc) acc_n++;
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    #1;
    chk("cap_accepts", 64'(acc_n), 64'd2);
    chk("cap_ready_low", 64'(bus.o_ready), 64'd0);
  endtask

  initial begin
    logic [63:0] e0, e1, held;
    int budget;
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    bus.i_valid  = 1'b0;
    bus.i_flin   = '0;
    bus.i_ke1    = '0;
    bus.i_ready  = 1'b1;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_flout", bus.o_flout, 64'h0);
    chk("rst_ready", 64'(bus.o_ready), 64'd0);
    rst = 1'b0;
    #1 chk("post_rst_ready", 64'(bus.o_ready), 64'd1);

    // Directed vectors
    run_one("basic",  64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'h0000_0003_0000_0002);
    run_one("rotwrap", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'h8000_0001_0000_0001);
    run_one("orpath", 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_FFFF_FFFF, 64'hEDCB_A987_9ABC_DEF0);
    run_one("zero",   64'h0, 64'h0, 64'h0);

    // Capacity and stall hold
    got_q.delete();
    fill_stalled(e0, e1);
    held = bus.o_flout;
    chk("stall_valid", 64'(bus.o_valid), 64'd1);
    chk("stall_head", held, e0);
    @(negedge clk);
    @(negedge clk);
    chk("stall_hold_data", bus.o_flout, held);
    chk("stall_hold_valid", 64'(bus.o_valid), 64'd1);
    bus.i_ready = 1'b1;
    budget = 0;
    while (got_q.size() < 2 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(negedge clk);
    chk("drain_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() >= 2) begin
      chk("drain_0", got_q[0], e0);
      chk("drain_1", got_q[1], e1);
    end

    // Random backpressure, then round trip
    run_stream("bp", 8, 1'b1, 1'b0);
    run_stream("bp2", 40, 1'b1, 1'b0);
    run_stream("rt", 1000, 1'b0, 1'b1);

    // Reset with both stages full
    got_q.delete();
    fill_stalled(e0, e1);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_ready", 64'(bus.o_ready), 64'd0);
    @(negedge clk);
    chk("midrst_valid", 64'(bus.o_valid), 64'd0);
    chk("midrst_flout", bus.o_flout, 64'h0);
    rst = 1'b0;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 4; c++) @(negedge clk);
    chk("midrst_no_stale", 64'(got_q.size()), 64'd0);
    run_one("after_rst", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
            fl_ref(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
